// File: rtl/sqrt_iter_pkg.sv
// Shared types and width helpers for the iterative integer square-root unit.
package sqrt_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Root width for a W-bit radicand.
    function automatic int root_w(input int w);
        return w / 2;
    endfunction

    // Remainder width: the largest remainder 2*(2^RW-1) needs one extra bit.
    function automatic int rem_w(input int w);
        return (w / 2) + 1;
    endfunction

endpackage

// File: rtl/sqrt_iter_if.sv
// Request/result bundle between a requester and sqrt_iter.
interface sqrt_iter_if #(parameter int W = 16);
    import sqrt_iter_pkg::*;

    logic                   start;
    logic [W-1:0]           A;
    logic                   busy;
    logic                   ack;
    logic [root_w(W)-1:0]   R;
    logic [rem_w(W)-1:0]    Rem;

    modport master (output start, A, input busy, ack, R, Rem);
    modport slave  (input start, A, output busy, ack, R, Rem);

endinterface

// File: rtl/sqrt_iter_step.sv
// One digit of the shift/subtract square root: resolves a single root bit.
module sqrt_iter_step #(
    parameter int RW = 8
) (
    input  logic [RW+1:0] r,
    input  logic [RW-1:0] q,
    input  logic [1:0]    bits,
    output logic [RW+1:0] r_nxt,
    output logic [RW-1:0] q_nxt
);
    logic [RW+1:0] r_sh;
    logic [RW+1:0] trial;
    logic          ge;
    logic [RW:0]   q_wide;

    // r never exceeds RW bits before a step, so the top two bits of r are dropped by the shift.
    assign r_sh   = {r[RW-1:0], bits};
    assign trial  = {q, 2'b01};
    assign ge     = (r_sh >= trial);
    assign r_nxt  = ge ? (r_sh - trial) : r_sh;
    assign q_wide = {q, ge};
    assign q_nxt  = q_wide[RW-1:0];

endmodule

// File: rtl/sqrt_iter.sv
// Iterative floor square root with remainder; one root bit per clock.
// Optional round-to-nearest root output: define SQRT_ITER_ROUND_EN.
module sqrt_iter
    import sqrt_iter_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst_n,
    sqrt_iter_if.slave   bus
);
    localparam int RW  = root_w(W);
    localparam int RMW = rem_w(W);
    localparam int CW  = (RW > 1) ? $clog2(RW) : 1;

    if ((W < 2) || ((W % 2) != 0)) begin : g_bad_w
        $error("sqrt_iter: W must be even and at least 2");
    end

    state_t          state;
    logic [W-1:0]    x;
    logic [RW-1:0]   q, q_nxt;
    logic [RW+1:0]   r, r_nxt;
    logic [CW-1:0]   i;
    logic [RW-1:0]   root;

    sqrt_iter_step #(.RW(RW)) u_step (
        .r     (r),
        .q     (q),
        .bits  (x[W-1 -: 2]),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

`ifdef SQRT_ITER_ROUND_EN
    // r > q on the final step means A >= q^2+q+1; an all-ones q saturates.
    always_comb begin
        root = q_nxt;
        if ((r_nxt > {2'b00, q_nxt}) && !(&q_nxt))
            root = q_nxt + 1'b1;
    end
`else
    assign root = q_nxt;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            x        <= '0;
            q        <= '0;
            r        <= '0;
            i        <= '0;
            bus.busy <= 1'b0;
            bus.ack  <= 1'b0;
            bus.R    <= '0;
            bus.Rem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x        <= bus.A;
                        q        <= '0;
                        r        <= '0;
                        i        <= CW'(RW - 1);
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    x <= x << 2;
                    q <= q_nxt;
                    r <= r_nxt;
                    if (i == '0) begin
                        bus.R   <= root;
                        bus.Rem <= r_nxt[RMW-1:0];
                        bus.ack <= 1'b1;
                        state   <= DONE;
                    end else begin
                        i <= i - 1'b1;
                    end
                end
                DONE: begin
                    bus.ack  <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
- Parametrised integer square-root unit. Successor to the multiply-and-compare square-root block.
- Computes floor(sqrt(A)) and the remainder using a digit-by-digit shift/subtract algorithm. Each cycle resolves one root bit, so latency is fixed and does not depend on the data.
- Uses the same start/ack handshake. Sits beside the multiplier in the arithmetic datapath.

Parameters:
- W, 16, operand width. Must be even and at least 2; any other value is an elaboration error.
- RW, W/2, root width (derived; do not override).

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE.
- A  in  W  radicand. Captured on the edge where start is accepted.
- busy  out  1  high whenever state is not IDLE.
- ack  out  1  one-cycle pulse: result valid.
- R  out  RW  root.
- Rem  out  RW+1  remainder, A - R*R (unrounded root).

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE; busy=0, ack=0, R=0, Rem=0; internal registers cleared.
  - Reset asserted mid-operation aborts the operation. No ack is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0: latch A into shift register X, clear partial root q and partial remainder r, iteration counter i=RW-1, go to CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per edge (edges E1..E_RW):
  - r' = (r<<2) | top two bits of X; X <<= 2; trial = (q<<2)|1.
  - If r' >= trial: r = r' - trial, q = (q<<1)|1. Otherwise r = r', q = q<<1.
  - r is held in RW+2 bits internally; no overflow is possible at that width.
  - On the edge where i==0 (E_RW): load R=q and Rem=r, set ack<=1, go to DONE. Otherwise i<=i-1.
- DONE (one cycle): ack<=0, go to IDLE.
- Timing:
  - ack is high during the cycle after E_RW, i.e. RW cycles after the accept edge. Minimum start-to-start spacing is RW+2 cycles.
  - busy is high from E0+ through the ack cycle.
- Output holding: R and Rem change only on the ack-load edge and hold until the next result or reset.
- start while busy (CALC or DONE) is ignored, not queued. If start is still high once back in IDLE, a new operation is accepted with the A sampled at that edge.
- A may change freely after the accept edge.
- Boundaries:
  - A=0 gives R=0, Rem=0.
  - A=2^W-1 gives R=2^RW-1, Rem=2^(RW+1)-2. This is the maximum, and it fits in RW+1 bits.

Optional Feature:
- Macro SQRT_ITER_ROUND_EN.
- Defined: on the DONE load, R = q+1 if r > q, else q. This is round-to-nearest (A >= q^2+q+1). The result saturates at 2^RW-1 if q+1 would overflow. Rem still reports A - q^2 (the floor remainder). Latency is unchanged.
- Undefined: R = floor root only, and no rounding comparator is built.

Decomposition:
- Package sqrt_iter_pkg: state encoding constants (IDLE, CALC, DONE), and the width-derivation function for RW and the remainder width.
- One natural sub-module, sqrt_iter_step: combinational single-iteration cell. Inputs are r, q and the two incoming bits; outputs are next r and next q. It is instantiated once and reused every cycle.

Test Plan:
- W=16, A=49, start pulsed one cycle: ack pulses exactly 8 cycles after the accept edge, with R=7, Rem=0; busy is high for 9 cycles.
- W=16, A=50: R=7, Rem=1. A=0: R=0, Rem=0. A=65535: R=255, Rem=510.
- Rounding, with SQRT_ITER_ROUND_EN: A=56 gives R=7 (Rem=7); A=57 gives R=8 (Rem=8); A=65535 gives R=255 (saturated). Without the macro, all three give R=7, 7, 255.
- start held high continuously with A=100 then A=144: consecutive acks 10 cycles apart, giving R=10 then R=12; start during CALC has no effect.
- Rst_n driven low 3 cycles into an operation on A=200: busy, ack, R and Rem all go to 0 immediately. No ack follows. A fresh start after release with A=200 gives R=14, Rem=4.
- Sweep with W=8 (RW=4): all A in 0..255 compared against a reference floor-sqrt, with ack at 4 cycles after accept each time.
